// File: rtl/instruction_decoder.sv
// Instruction decoder: combinational decode of the program-memory word
// plus zero flag, jump watchdog and last-instruction debug register.
module instruction_decoder #(
  parameter int unsigned WDT_LIMIT = 200
) (
  input  logic       clk,
  input  logic       sync_reset,
  input  logic [7:0] pm_data,
  input  logic       alu_zero,
  output logic       jmp,
  output logic       jmp_nz,
  output logic       dont_jmp,
  output logic       jmp_count,
  output logic [3:0] jmp_addr,
  output logic [7:0] reg_en,
  output logic [2:0] src_sel,
  output logic       imm_sel,
  output logic       alu_en,
  output logic [3:0] alu_func,
  output logic       alu_y_sel,
  output logic [7:0] ir_last
);

  localparam int CW =
    (WDT_LIMIT > 0) ? $clog2(WDT_LIMIT + 1) : 1;
  localparam logic [CW-1:0] LIM = CW'(WDT_LIMIT);
  localparam bit WDT_ON = (WDT_LIMIT != 0);

  logic          flag_q, flag_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    ir_q, ir_d;
  logic          wdt_fire;
  logic          taken;

  // Watchdog fires once the count reaches the limit; reset masks it.
  always_comb begin
    wdt_fire = 1'b0;
    if (WDT_ON && !sync_reset && (cnt_q == LIM))
      wdt_fire = 1'b1;
  end

  // Decode the current instruction; a watchdog cycle abandons it.
  always_comb begin
    reg_en    = 8'h00;
    src_sel   = 3'd0;
    imm_sel   = 1'b0;
    alu_en    = 1'b0;
    alu_func  = 4'h0;
    alu_y_sel = 1'b0;
    jmp       = 1'b0;
    jmp_nz    = 1'b0;
    if (!sync_reset) begin
      unique case (1'b1)
        (pm_data[7] == 1'b0): begin
          reg_en  = 8'h01 << pm_data[6:4];
          imm_sel = 1'b1;
        end
        (pm_data[7:6] == 2'b10): begin
          src_sel = pm_data[2:0];
          if (pm_data[5:3] != pm_data[2:0])
            reg_en = 8'h01 << pm_data[5:3];
        end
        (pm_data[7:5] == 3'b110): begin
          alu_en    = 1'b1;
          alu_y_sel = pm_data[4];
          alu_func  = pm_data[3:0];
        end
        (pm_data[7:4] == 4'hE): begin
          jmp = 1'b1;
        end
        default: begin
          jmp_nz = 1'b1;
        end
      endcase
    end
    if (wdt_fire) begin
      reg_en = 8'h00;
      alu_en = 1'b0;
      jmp    = 1'b0;
      jmp_nz = 1'b0;
    end
  end

  // Next state for flag, watchdog count and debug register.
  always_comb begin
    taken  = jmp | (jmp_nz & ~flag_q);
    flag_d = flag_q;
    if (alu_en)
      flag_d = alu_zero;
    cnt_d = cnt_q + CW'(1);
    if (taken || wdt_fire)
      cnt_d = '0;
    ir_d = pm_data;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      flag_q <= 1'b0;
      cnt_q  <= '0;
      ir_q   <= 8'h00;
    end else begin
      flag_q <= flag_d;
      cnt_q  <= cnt_d;
      ir_q   <= ir_d;
    end
  end

  assign dont_jmp  = flag_q;
  assign jmp_count = wdt_fire;
  assign jmp_addr  = pm_data[3:0];
  assign ir_last   = ir_q;

endmodule

// File: tb/tb_instruction_decoder.sv
// Scoreboard bench for instruction_decoder with a 4-cycle watchdog.
// A behavioural model predicts every output each cycle.
module tb_instruction_decoder;

  localparam int unsigned LIM = 4;

  logic       clk = 1'b0;
  logic       sync_reset = 1'b1;
  logic [7:0] pm_data = 8'h00;
  logic       alu_zero = 1'b0;
  logic       jmp, jmp_nz, dont_jmp, jmp_count;
  logic [3:0] jmp_addr;
  logic [7:0] reg_en;
  logic [2:0] src_sel;
  logic       imm_sel, alu_en, alu_y_sel;
  logic [3:0] alu_func;
  logic [7:0] ir_last;

  instruction_decoder #(.WDT_LIMIT(LIM)) dut (
    .clk       (clk),
    .sync_reset(sync_reset),
    .pm_data   (pm_data),
    .alu_zero  (alu_zero),
    .jmp       (jmp),
    .jmp_nz    (jmp_nz),
    .dont_jmp  (dont_jmp),
    .jmp_count (jmp_count),
    .jmp_addr  (jmp_addr),
    .reg_en    (reg_en),
    .src_sel   (src_sel),
    .imm_sel   (imm_sel),
    .alu_en    (alu_en),
    .alu_func  (alu_func),
    .alu_y_sel (alu_y_sel),
    .ir_last   (ir_last)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] reg_en;
    logic [2:0] src_sel;
    logic       imm_sel;
    logic       alu_en;
    logic [3:0] alu_func;
    logic       alu_y_sel;
    logic       jmp;
    logic       jmp_nz;
    logic       dont_jmp;
    logic       jmp_count;
    logic [3:0] jmp_addr;
    logic [7:0] ir_last;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_err = 0;

  logic       m_flag = 1'b0;
  int         m_cnt = 0;
  logic [7:0] m_ir = 8'h00;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h t=%0t",
               tag, obs, exp, $time);
    end
  endtask

  function automatic exp_t predict(input logic rst,
                                   input logic [7:0] pm);
    exp_t e;
    logic [2:0] d, s;
    e = '0;
    e.jmp_addr  = pm[3:0];
    e.dont_jmp  = m_flag;
    e.ir_last   = m_ir;
    e.jmp_count = !rst && (m_cnt == LIM);
    if (!rst) begin
      d = pm[5:3];
      s = pm[2:0];
      casez (pm)
        8'b0???????: begin
          e.reg_en[pm[6:4]] = 1'b1;
          e.imm_sel = 1'b1;
        end
        8'b10??????: begin
          e.src_sel = s;
          if (d != s) e.reg_en[d] = 1'b1;
        end
        8'b110?????: begin
          e.alu_en = 1'b1;
          e.alu_y_sel = pm[4];
          e.alu_func = pm[3:0];
        end
        8'b1110????: e.jmp = 1'b1;
        default:     e.jmp_nz = 1'b1;
      endcase
    end
    if (e.jmp_count) begin
      e.reg_en = '0;
      e.alu_en = 1'b0;
      e.jmp = 1'b0;
      e.jmp_nz = 1'b0;
    end
    return e;
  endfunction

  task automatic step(input logic rst,
                      input logic [7:0] pm,
                      input logic az);
    exp_t e, x;
    bit tk;
    @(posedge clk);
    #1;
    sync_reset = rst;
    pm_data = pm;
    alu_zero = az;
    e = predict(rst, pm);
    q.push_back(e);
    #4;
    x = q.pop_front();
    chk("reg_en",    32'(reg_en),    32'(x.reg_en));
    chk("src_sel",   32'(src_sel),   32'(x.src_sel));
    chk("imm_sel",   32'(imm_sel),   32'(x.imm_sel));
    chk("alu_en",    32'(alu_en),    32'(x.alu_en));
    chk("alu_func",  32'(alu_func),  32'(x.alu_func));
    chk("alu_y_sel", 32'(alu_y_sel), 32'(x.alu_y_sel));
    chk("jmp",       32'(jmp),       32'(x.jmp));
    chk("jmp_nz",    32'(jmp_nz),    32'(x.jmp_nz));
    chk("dont_jmp",  32'(dont_jmp),  32'(x.dont_jmp));
    chk("jmp_count", 32'(jmp_count), 32'(x.jmp_count));
    chk("jmp_addr",  32'(jmp_addr),  32'(x.jmp_addr));
    chk("ir_last",   32'(ir_last),   32'(x.ir_last));
    if (rst) begin
      m_flag = 1'b0;
      m_cnt = 0;
      m_ir = 8'h00;
    end else begin
      tk = x.jmp || (x.jmp_nz && !m_flag);
      if (x.alu_en) m_flag = az;
      m_cnt = (tk || x.jmp_count) ? 0 : m_cnt + 1;
      m_ir = pm;
    end
  endtask

  initial begin
    step(1, 8'hFF, 1'b0);
    step(1, 8'hE5, 1'b1);
    chk("rst_outs", 32'({jmp, jmp_nz, alu_en, reg_en}), 32'h0);
    // c0..c2: immediate, jmp, jnz taken
    step(0, 8'h35, 1'b0);
    chk("li_reg_en", 32'(reg_en), 32'h08);
    chk("li_imm", 32'(imm_sel), 32'h1);
    chk("li_ir0", 32'(ir_last), 32'h00);
    step(0, 8'hE7, 1'b0);
    chk("jmp_hi", 32'({jmp, jmp_addr}), 32'h17);
    chk("li_ir1", 32'(ir_last), 32'h35);
    step(0, 8'hF3, 1'b0);
    // c3..c6: ALU sets flag then clears it
    step(0, 8'hC2, 1'b1);
    step(0, 8'hF5, 1'b0);
    chk("flag_set", 32'(dont_jmp), 32'h1);
    step(0, 8'hC2, 1'b0);
    step(0, 8'hF5, 1'b0);
    chk("flag_clr", 32'(dont_jmp), 32'h0);
    // c7..c10: moves and NOP moves
    step(0, 8'h8B, 1'b0);
    chk("mv_reg_en", 32'({reg_en, src_sel}), 32'h013);
    step(0, 8'h92, 1'b0);
    chk("nop_reg_en", 32'(reg_en), 32'h00);
    step(0, 8'h9B, 1'b0);
    step(0, 8'hD7, 1'b1);
    // c11: watchdog cycle swallows a jump
    step(0, 8'hE1, 1'b0);
    chk("wdt_pulse", 32'({jmp_count, jmp}), 32'h2);
    for (int i = 0; i < 4; i++) step(0, 8'h92, 1'b0);
    // ALU in a pulse cycle must not touch the flag
    step(0, 8'hC0, 1'b0);
    chk("wdt_alu", 32'({jmp_count, alu_en}), 32'h2);
    step(0, 8'hF0, 1'b0);
    chk("flag_hold", 32'(dont_jmp), 32'h1);
    step(0, 8'h92, 1'b0);
    step(0, 8'h92, 1'b0);
    // reset at count 3: no pulse, count restarts
    step(1, 8'h92, 1'b0);
    chk("rst_nopulse", 32'(jmp_count), 32'h0);
    for (int i = 0; i < 10; i++) step(0, 8'h92, 1'b0);
    for (int i = 0; i < 300; i++) begin
      logic [7:0] p;
      p = 8'($urandom_range(0, 8'hDF));
      if ($urandom_range(0, 9) == 0) p = 8'($urandom_range(8'hE0, 8'hFF));
      step($urandom_range(0, 39) == 0, p, 1'($urandom));
    end
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL queue: got %0d expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule
